// File: rtl/pal_sync_generator.sv
// pal_sync_generator: free-running 625-line interlaced PAL sync timing.
// The internal position counters run one cycle ahead of the registered outputs.
// Every output, including hCount/lineNumber, is a registered decode of the
// previous position, so the counters and the syncs stay aligned downstream.
module pal_sync_generator #(
    parameter int LINE_CLKS       = 864,
    parameter int HSYNC_CLKS      = 64,
    parameter int EQ_CLKS         = 32,
    parameter int BROAD_CLKS      = 368,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    output logic       hSync,
    output logic       vSync,
    output logic       cSync,
    output logic       field,
    output logic [9:0] hCount,
    output logic [9:0] lineNumber,
    output logic       lineStart,
    output logic       frameStart
);
    // pulse  | meaning
    // NONE   | no sync pulse in this half-line
    // NORMAL | line sync, HSYNC_CLKS wide
    // EQ     | equalising pulse, EQ_CLKS wide
    // BROAD  | field-sync broad pulse, BROAD_CLKS wide
    typedef enum logic [1:0] {P_NONE, P_NORMAL, P_EQ, P_BROAD} pulse_t;

    localparam logic [9:0] LAST_H   = 10'(LINE_CLKS - 1);
    localparam logic [9:0] HALF_H   = 10'(LINE_CLKS / 2);
    localparam logic       INACTIVE = SYNC_ACTIVE_LOW;

    logic [9:0] h_q, h_d;
    logic [9:0] line_q, line_d;
    logic [9:0] hcount_q, line_num_q;
    logic       hsync_q, vsync_q, csync_q, field_q;
    logic       line_start_q, frame_start_q;

    pulse_t     pulse_a, pulse_b, pulse_cur;
    logic       in_half_b;
    logic [9:0] offset, width;
    logic       pulse_on;
    logic       hsync_d, vsync_d, csync_d, field_d;

    // Half-line pulse schedule for the current line (half A / half B)
    always_comb begin
        pulse_a = P_NORMAL;
        pulse_b = P_NONE;
        if (line_q <= 10'd2) begin
            pulse_a = P_BROAD;  pulse_b = P_BROAD;
        end else if (line_q == 10'd3) begin
            pulse_a = P_BROAD;  pulse_b = P_EQ;
        end else if (line_q <= 10'd5) begin
            pulse_a = P_EQ;     pulse_b = P_EQ;
        end else if (line_q <= 10'd310) begin
            pulse_a = P_NORMAL; pulse_b = P_NONE;
        end else if (line_q <= 10'd312) begin
            pulse_a = P_EQ;     pulse_b = P_EQ;
        end else if (line_q == 10'd313) begin
            pulse_a = P_EQ;     pulse_b = P_BROAD;
        end else if (line_q <= 10'd315) begin
            pulse_a = P_BROAD;  pulse_b = P_BROAD;
        end else if (line_q <= 10'd317) begin
            pulse_a = P_EQ;     pulse_b = P_EQ;
        end else if (line_q == 10'd318) begin
            pulse_a = P_EQ;     pulse_b = P_NONE;
        end else if (line_q <= 10'd622) begin
            pulse_a = P_NORMAL; pulse_b = P_NONE;
        end else if (line_q == 10'd623) begin
            pulse_a = P_NORMAL; pulse_b = P_EQ;
        end else begin
            pulse_a = P_EQ;     pulse_b = P_EQ;
        end
    end

    // Position within the half-line and whether its pulse is still running
    always_comb begin
        in_half_b = (h_q >= HALF_H);
        offset    = in_half_b ? (h_q - HALF_H) : h_q;
        pulse_cur = in_half_b ? pulse_b : pulse_a;
        case (pulse_cur)
            P_NORMAL: width = 10'(HSYNC_CLKS);
            P_EQ:     width = 10'(EQ_CLKS);
            P_BROAD:  width = 10'(BROAD_CLKS);
            default:  width = 10'd0;
        endcase
        pulse_on = (offset < width);
        csync_d  = INACTIVE ^ pulse_on;
        hsync_d  = INACTIVE ^ (pulse_on && (pulse_cur == P_NORMAL));
        vsync_d  = INACTIVE ^ (pulse_on && (pulse_cur == P_BROAD));
        field_d  = (line_q >= 10'd313);
    end

    // Next horizontal/line position
    always_comb begin
        h_d    = h_q + 10'd1;
        line_d = line_q;
        if (h_q == LAST_H) begin
            h_d    = '0;
            line_d = (line_q == 10'd625) ? 10'd1 : (line_q + 10'd1);
        end
    end

    // Counters and registered output decode; reset wins over enable
    always_ff @(posedge clock) begin
        if (reset) begin
            h_q           <= '0;
            line_q        <= 10'd1;
            hcount_q      <= '0;
            line_num_q    <= 10'd1;
            hsync_q       <= INACTIVE;
            vsync_q       <= INACTIVE;
            csync_q       <= INACTIVE;
            field_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (enable) begin
            h_q           <= h_d;
            line_q        <= line_d;
            hcount_q      <= h_q;
            line_num_q    <= line_q;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            csync_q       <= csync_d;
            field_q       <= field_d;
            line_start_q  <= (h_q == 10'd0);
            frame_start_q <= (h_q == 10'd0) && (line_q == 10'd1);
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign hSync      = hsync_q;
    assign vSync      = vsync_q;
    assign cSync      = csync_q;
    assign field      = field_q;
    assign hCount     = hcount_q;
    assign lineNumber = line_num_q;
    assign lineStart  = line_start_q;
    assign frameStart = frame_start_q;

endmodule

// File: tb/tb_pal_sync_generator.sv
// Bench for pal_sync_generator: three instances (short-line active-low,
// short-line active-high, default geometry) share clock, reset and enable.
// A schedule-table model predicts every output cycle into a scoreboard queue;
// a negedge monitor pops and compares. Directed checks cover the frame period,
// the enable freeze and a mid-frame reset.
`timescale 1ns/1ps
module tb_pal_sync_generator;
    localparam int NI = 3;
    localparam int S_LINE = 48;
    localparam int T_NONE = 0, T_NORM = 1, T_EQ = 2, T_BR = 3;

    typedef struct {
        logic hs, vs, cs, fld, ls, fs;
        int   hc, ln;
    } exp_t;

    int p_line [NI] = '{S_LINE, S_LINE, 864};
    int p_hs   [NI] = '{6, 6, 64};
    int p_eq   [NI] = '{3, 3, 32};
    int p_br   [NI] = '{18, 18, 368};
    bit p_low  [NI] = '{1'b1, 1'b0, 1'b1};

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    always #5 clock = ~clock;

    logic [NI-1:0]       hs, vs, cs, fld, ls, fs;
    logic [NI-1:0][9:0]  hc, ln;

    pal_sync_generator #(.LINE_CLKS(48), .HSYNC_CLKS(6), .EQ_CLKS(3), .BROAD_CLKS(18),
                         .SYNC_ACTIVE_LOW(1'b1)) u_lo (
        .clock(clock), .reset(reset), .enable(enable),
        .hSync(hs[0]), .vSync(vs[0]), .cSync(cs[0]), .field(fld[0]),
        .hCount(hc[0]), .lineNumber(ln[0]), .lineStart(ls[0]), .frameStart(fs[0]));

    pal_sync_generator #(.LINE_CLKS(48), .HSYNC_CLKS(6), .EQ_CLKS(3), .BROAD_CLKS(18),
                         .SYNC_ACTIVE_LOW(1'b0)) u_hi (
        .clock(clock), .reset(reset), .enable(enable),
        .hSync(hs[1]), .vSync(vs[1]), .cSync(cs[1]), .field(fld[1]),
        .hCount(hc[1]), .lineNumber(ln[1]), .lineStart(ls[1]), .frameStart(fs[1]));

    pal_sync_generator u_def (
        .clock(clock), .reset(reset), .enable(enable),
        .hSync(hs[2]), .vSync(vs[2]), .cSync(cs[2]), .field(fld[2]),
        .hCount(hc[2]), .lineNumber(ln[2]), .lineStart(ls[2]), .frameStart(fs[2]));

    int   n_checks = 0;
    int   n_err    = 0;
    int   sched_a [1:625];
    int   sched_b [1:625];
    int   mh [NI];
    int   ml [NI];
    exp_t last_e [NI];
    exp_t sbq [$];

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic fill(input int f, input int l, input int a, input int b);
        for (int n = f; n <= l; n++) begin
            sched_a[n] = a;
            sched_b[n] = b;
        end
    endtask

    function automatic exp_t reset_exp(input int i);
        exp_t e;
        e.hs = p_low[i]; e.vs = p_low[i]; e.cs = p_low[i];
        e.fld = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
        e.hc = 0; e.ln = 1;
        return e;
    endfunction

    // What the outputs show one cycle after the counters sat at (line, h)
    function automatic exp_t expect_at(input int i, input int h, input int line);
        exp_t e;
        int   half, off, t, w;
        logic on, lo;
        half = p_line[i] / 2;
        if (h < half) begin
            off = h;        t = sched_a[line];
        end else begin
            off = h - half; t = sched_b[line];
        end
        w  = (t == T_NORM) ? p_hs[i] : (t == T_EQ) ? p_eq[i] : (t == T_BR) ? p_br[i] : 0;
        on = (off < w);
        lo = p_low[i];
        e.cs  = on ? ~lo : lo;
        e.hs  = (on && t == T_NORM) ? ~lo : lo;
        e.vs  = (on && t == T_BR) ? ~lo : lo;
        e.fld = (line > 312);
        e.ls  = (h == 0);
        e.fs  = (h == 0) && (line == 1);
        e.hc  = h;
        e.ln  = line;
        return e;
    endfunction

    // Reference model: predicts each instance's outputs after this edge
    always @(posedge clock) begin
        for (int i = 0; i < NI; i++) begin
            exp_t e;
            if (reset) begin
                e = reset_exp(i);
                mh[i] = 0;
                ml[i] = 1;
            end else if (enable) begin
                e = expect_at(i, mh[i], ml[i]);
                mh[i] = mh[i] + 1;
                if (mh[i] == p_line[i]) begin
                    mh[i] = 0;
                    ml[i] = (ml[i] == 625) ? 1 : ml[i] + 1;
                end
            end else begin
                e = last_e[i];
                e.ls = 1'b0;
                e.fs = 1'b0;
            end
            last_e[i] = e;
            sbq.push_back(e);
        end
    end

    // Monitor: compare every instance's full output set each cycle
    always @(negedge clock) begin
        for (int i = 0; i < NI; i++) begin
            exp_t e;
            logic [25:0] got, want;
            n_checks++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL sb_empty[%0d]: got 0 queued entries, expected at least 1", i);
            end else begin
                e    = sbq.pop_front();
                got  = {hs[i], vs[i], cs[i], fld[i], ls[i], fs[i], hc[i], ln[i]};
                want = {e.hs, e.vs, e.cs, e.fld, e.ls, e.fs, 10'(e.hc), 10'(e.ln)};
                if (got != want) begin
                    n_err++;
                    $display("FAIL out[%0d]: got hs=%b vs=%b cs=%b fld=%b ls=%b fs=%b h=%0d ln=%0d, expected hs=%b vs=%b cs=%b fld=%b ls=%b fs=%b h=%0d ln=%0d",
                             i, hs[i], vs[i], cs[i], fld[i], ls[i], fs[i], hc[i], ln[i],
                             e.hs, e.vs, e.cs, e.fld, e.ls, e.fs, e.hc, e.ln);
                end
            end
        end
        if (n_err >= 100) finish_run();
    end

    initial begin
        #2_000_000;
        n_checks++;
        n_err++;
        $display("FAIL watchdog: got no end of run, expected completion before 2 ms");
        finish_run();
    end

    initial begin
        int   cnt, first_k;
        logic found, prev_field;

        fill(1, 2, T_BR, T_BR);       fill(3, 3, T_BR, T_EQ);
        fill(4, 5, T_EQ, T_EQ);       fill(6, 310, T_NORM, T_NONE);
        fill(311, 312, T_EQ, T_EQ);   fill(313, 313, T_EQ, T_BR);
        fill(314, 315, T_BR, T_BR);   fill(316, 317, T_EQ, T_EQ);
        fill(318, 318, T_EQ, T_NONE); fill(319, 622, T_NORM, T_NONE);
        fill(623, 623, T_NORM, T_EQ); fill(624, 625, T_EQ, T_EQ);

        reset = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        found = 1'b0;
        first_k = -1;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clock);
            if (fs[0]) begin
                found = 1'b1;
                first_k = k;
            end
        end
        chk("first_framestart_seen", int'(found), 1);
        chk("first_framestart_cycle", first_k, 0);

        cnt = 0;
        found = 1'b0;
        prev_field = fld[0];
        while (!found && cnt < 31000) begin
            @(negedge clock);
            cnt++;
            if (fs[0]) begin
                found = 1'b1;
                chk("field_before_wrap", int'(prev_field), 1);
                chk("field_after_wrap", int'(fld[0]), 0);
                chk("line_after_wrap", int'(ln[0]), 1);
            end
            prev_field = fld[0];
        end
        chk("frame_interval", cnt, 625 * S_LINE);

        cnt = 0;
        while (!(ml[0] == 100 && mh[0] == 21) && cnt < 10000) begin
            @(negedge clock);
            cnt++;
        end
        chk("reach_line100", int'(ml[0] == 100 && mh[0] == 21), 1);
        enable = 1'b0;
        repeat (10) begin
            @(negedge clock);
            chk("freeze_h", int'(hc[0]), 20);
            chk("freeze_line", int'(ln[0]), 100);
            chk("freeze_linestart", int'(ls[0]), 0);
        end
        enable = 1'b1;
        @(negedge clock);
        chk("resume_h", int'(hc[0]), 21);
        chk("resume_line", int'(ln[0]), 100);

        cnt = 0;
        while (ml[0] != 200 && cnt < 20000) begin
            enable = ($urandom_range(0, 7) != 0);
            @(negedge clock);
            cnt++;
        end
        chk("reach_line200", ml[0], 200);

        reset = 1'b1;
        enable = 1'($urandom_range(0, 1));
        @(negedge clock);
        chk("rst_h", int'(hc[0]), 0);
        chk("rst_line", int'(ln[0]), 1);
        chk("rst_field", int'(fld[0]), 0);
        chk("rst_cs_activelow", int'(cs[0]), 1);
        chk("rst_cs_activehigh", int'(cs[1]), 0);
        chk("rst_vs_activehigh", int'(vs[1]), 0);
        chk("rst_framestart", int'(fs[2]), 0);
        reset = 1'b0;

        repeat (200) begin
            enable = ($urandom_range(0, 5) != 0);
            @(negedge clock);
        end
        enable = 1'b1;
        @(negedge clock);
        finish_run();
    end

endmodule
